// File: rtl/lsu_mem_access_unit_pkg.sv
// Shared ISA/LSU types: funct3 encodings, access sizes, LSU FSM states and decode helpers.
package lsu_mem_access_unit_pkg;

  localparam int LSU_BUS_BYTES = 4;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } i_function3_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } s_function3_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_access_type_e;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ISSUE,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_e;

  function automatic logic [LSU_BUS_BYTES-1:0] lsu_size_mask(input mem_access_type_e size);
    case (size)
      MEM_BYTE: return 4'b0001;
      MEM_HALF: return 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic lsu_illegal(input logic store, input logic [2:0] f3);
    if (store) return f3[2] || (f3[1:0] == 2'b11);
    return !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  endfunction

  // A half at offset 1 stays inside one word, so only offset 3 crosses.
  function automatic logic lsu_misaligned(input mem_access_type_e size, input logic [1:0] off);
    return ((size == MEM_HALF) && (off == 2'd3)) || ((size == MEM_WORD) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_mem_access_unit_lane_align.sv
// Combinational byte-lane steering: store shift/strobes for both beats, load merge and extension.
module lsu_mem_access_unit_lane_align
  import lsu_mem_access_unit_pkg::*;
(
  input  mem_access_type_e size,
  input  logic             uns,
  input  logic [1:0]       off,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rdata0,
  input  logic [31:0]      rdata1,
  output logic [3:0]       wstrb0,
  output logic [3:0]       wstrb1,
  output logic [31:0]      wdata0,
  output logic [31:0]      wdata1,
  output logic [31:0]      ldata
);

  logic [7:0]  strb_wide;
  logic [63:0] wdata_wide;
  logic [31:0] rshift;

  // Shifting into a double-width vector yields beat0 in the low half and beat1 in the high half.
  always_comb begin
    strb_wide  = {4'b0000, lsu_size_mask(size)} << off;
    wdata_wide = {32'h0, wdata} << {off, 3'b000};
    rshift     = 32'({rdata1, rdata0} >> {off, 3'b000});
    wstrb0     = strb_wide[3:0];
    wstrb1     = strb_wide[7:4];
    wdata0     = wdata_wide[31:0];
    wdata1     = wdata_wide[63:32];
    case (size)
      MEM_BYTE: ldata = uns ? {24'h0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
      MEM_HALF: ldata = uns ? {16'h0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default:  ldata = rshift;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access_unit.sv
// Load/store unit: request latch, bus beat FSM with watchdog, response generation.
// Build option: LSU_MISALIGNED_SPLIT_EN splits misaligned accesses into two aligned beats.
module lsu_mem_access_unit
  import lsu_mem_access_unit_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_err
);

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state;
  mem_access_type_e  size_q;
  logic              uns_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] base_q;
  logic              split_q;
  logic              beat_q;
  logic [31:0]       rdata0_q;
  logic [CNT_W-1:0]  cnt;

  mem_access_type_e  req_size;
  logic              req_bad;
  logic              req_mis;
  mem_access_type_e  al_size;
  logic              al_uns;
  logic [1:0]        al_off;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata0;
  logic [31:0]       al_rdata1;
  logic [3:0]        al_wstrb0;
  logic [3:0]        al_wstrb1;
  logic [31:0]       al_wdata0;
  logic [31:0]       al_wdata1;
  logic [31:0]       al_ldata;
  logic              beat_done;
  logic              timeout;

  always_comb begin
    req_size = mem_access_type_e'(req_funct3[1:0]);
    req_bad  = lsu_illegal(req_store, req_funct3);
    req_mis  = lsu_misaligned(req_size, req_addr[1:0]);
  end

  // In IDLE the aligner sees the incoming request so beat0 can be registered on accept.
  always_comb begin
    if (state == LSU_IDLE) begin
      al_size  = req_size;
      al_uns   = req_funct3[2];
      al_off   = req_addr[1:0];
      al_wdata = req_wdata;
    end else begin
      al_size  = size_q;
      al_uns   = uns_q;
      al_off   = off_q;
      al_wdata = wdata_q;
    end
    al_rdata0 = split_q ? rdata0_q : bus_rdata;
    al_rdata1 = split_q ? bus_rdata : 32'h0;
  end

  lsu_mem_access_unit_lane_align u_align (
    .size   (al_size),
    .uns    (al_uns),
    .off    (al_off),
    .wdata  (al_wdata),
    .rdata0 (al_rdata0),
    .rdata1 (al_rdata1),
    .wstrb0 (al_wstrb0),
    .wstrb1 (al_wstrb1),
    .wdata0 (al_wdata0),
    .wdata1 (al_wdata1),
    .ldata  (al_ldata)
  );

  always_comb begin
    beat_done = ((state == LSU_ISSUE) && bus_ready && bus_rvalid) ||
                ((state == LSU_WAIT) && bus_rvalid);
    timeout   = (TIMEOUT_CYCLES != 0) && (state == LSU_WAIT) && !bus_rvalid && (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LSU_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
      size_q     <= MEM_BYTE;
      uns_q      <= 1'b0;
      off_q      <= '0;
      wdata_q    <= '0;
      base_q     <= '0;
      split_q    <= 1'b0;
      beat_q     <= 1'b0;
      rdata0_q   <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            size_q    <= req_size;
            uns_q     <= req_funct3[2];
            off_q     <= req_addr[1:0];
            wdata_q   <= req_wdata;
            base_q    <= {req_addr[ADDR_W-1:2], 2'b00};
            split_q   <= SPLIT_EN && req_mis;
            beat_q    <= 1'b0;
            if (req_bad || (req_mis && !SPLIT_EN)) begin
              state      <= LSU_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else begin
              state     <= LSU_ISSUE;
              bus_valid <= 1'b1;
              bus_we    <= req_store;
              bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              bus_wstrb <= req_store ? al_wstrb0 : 4'b0000;
              bus_wdata <= req_store ? al_wdata0 : 32'h0;
            end
          end
        end
        LSU_ISSUE, LSU_WAIT: begin
          if ((state == LSU_ISSUE) && bus_ready) bus_valid <= 1'b0;
          if (beat_done) begin
            if (bus_err) begin
              state      <= LSU_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
              bus_we     <= 1'b0;
              bus_wstrb  <= '0;
            end else if (split_q && !beat_q) begin
              state     <= LSU_ISSUE;
              beat_q    <= 1'b1;
              rdata0_q  <= bus_rdata;
              bus_valid <= 1'b1;
              bus_addr  <= base_q + ADDR_W'(LSU_BUS_BYTES);
              bus_wstrb <= bus_we ? al_wstrb1 : 4'b0000;
              bus_wdata <= bus_we ? al_wdata1 : 32'h0;
            end else begin
              state      <= LSU_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_data  <= bus_we ? 32'h0 : al_ldata;
              bus_we     <= 1'b0;
              bus_wstrb  <= '0;
            end
          end else if (timeout) begin
            state      <= LSU_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= '0;
            bus_we     <= 1'b0;
            bus_wstrb  <= '0;
          end else if (state == LSU_ISSUE) begin
            if (bus_ready) begin
              state <= LSU_WAIT;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state      <= LSU_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access_unit.sv
// Scoreboard bench for lsu_mem_access_unit: directed loads/stores against a scripted bus responder.
module tb_lsu_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;

  typedef struct {logic [31:0] data; logic err; int lat;} resp_t;
  typedef struct {logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata;} beat_t;
  typedef struct {int rdy; int rv; logic [31:0] rdata; logic err; bit no_rv; bit never; int late;} cfg_t;

  resp_t exp_resp_q[$];
  beat_t exp_beat_q[$];
  cfg_t  cfg_q[$];

  lsu_mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_resp(input logic [31:0] d, input logic e, input int lat);
    resp_t r;
    r.data = d; r.err = e; r.lat = lat;
    exp_resp_q.push_back(r);
  endtask

  task automatic exp_beat(input logic [31:0] a, input logic we, input logic [3:0] s, input logic [31:0] wd);
    beat_t b;
    b.addr = a; b.we = we; b.strb = s; b.wdata = wd;
    exp_beat_q.push_back(b);
  endtask

  task automatic bus_cfg(input int rdy, input int rv, input logic [31:0] rd, input logic e,
                         input bit no_rv, input bit never, input int late);
    cfg_t c;
    c.rdy = rdy; c.rv = rv; c.rdata = rd; c.err = e; c.no_rv = no_rv; c.never = never; c.late = late;
    cfg_q.push_back(c);
  endtask

  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_send", req_ready, 1'b1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_resp_q.size() > 0 || cfg_q.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_resp_q.size() > 0) begin
      errors++;
      $display("FAIL resp_wait: %0d responses outstanding, expected 0", exp_resp_q.size());
      exp_resp_q.delete();
    end
    check("beats_left", exp_beat_q.size(), 0);
    exp_beat_q.delete();
    cfg_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // Bus responder: one scripted behaviour per beat; beat contents are compared at the handshake.
  initial begin
    cfg_t  c;
    beat_t b;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus_valid) begin
        if (cfg_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat: got beat at 0x%08h, expected none", bus_addr);
          c.rdy = 0; c.rv = 0; c.rdata = '0; c.err = 1'b0; c.no_rv = 1'b0; c.never = 1'b0; c.late = 0;
        end else begin
          c = cfg_q.pop_front();
        end
        if (c.never) begin
          while (bus_valid) @(negedge clk);
        end else begin
          repeat (c.rdy) @(negedge clk);
          check("beat_valid_held", bus_valid, 1'b1);
          if (exp_beat_q.size() > 0) begin
            b = exp_beat_q.pop_front();
            check("beat_addr", bus_addr, b.addr);
            check("beat_we", bus_we, b.we);
            check("beat_wstrb", bus_wstrb, b.strb);
            if (b.we) check("beat_wdata", bus_wdata, b.wdata);
          end
          hs_cyc = cyc + 1;
          bus_ready = 1'b1;
          if (!c.no_rv && c.rv == 0) begin
            bus_rvalid = 1'b1; bus_rdata = c.rdata; bus_err = c.err;
          end
          @(negedge clk);
          bus_ready = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
          if (!c.no_rv && c.rv > 0) begin
            repeat (c.rv - 1) @(negedge clk);
            bus_rvalid = 1'b1; bus_rdata = c.rdata; bus_err = c.err;
            @(negedge clk);
            bus_rvalid = 1'b0; bus_err = 1'b0;
          end
          if (c.no_rv && c.late > 0) begin
            repeat (c.late - 1) @(negedge clk);
            bus_rvalid = 1'b1; bus_rdata = 32'hBAD0BAD0;
            @(negedge clk);
            bus_rvalid = 1'b0;
          end
        end
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n && resp_valid) begin
      if (exp_resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_resp: got data 0x%08h err %0b, expected no response", resp_data, resp_err);
      end else begin
        e = exp_resp_q.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_err", resp_err, e.err);
        if (e.lat >= 0) check("resp_latency", cyc - hs_cyc, e.lat);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_bus_valid", bus_valid, 1'b0);
    check("rst_bus_we", bus_we, 1'b0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_bus_wstrb", bus_wstrb, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // LW, rvalid two cycles after the handshake
    bus_cfg(0, 2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 0);
    exp_beat(32'h100, 1'b0, 4'b0000, 32'h0);
    exp_resp(32'hDEADBEEF, 1'b0, 2);
    send(1'b0, 3'b010, 32'h100, 32'h0);
    wait_done();

    // LB / LBU at offset 3, LHU at offset 2 (rvalid together with ready), LH at offset 1
    bus_cfg(0, 1, 32'h80112233, 1'b0, 1'b0, 1'b0, 0);
    exp_beat(32'h100, 1'b0, 4'b0000, 32'h0);
    exp_resp(32'hFFFFFF80, 1'b0, -1);
    send(1'b0, 3'b000, 32'h103, 32'h0);
    wait_done();
    bus_cfg(0, 1, 32'h80112233, 1'b0, 1'b0, 1'b0, 0);
    exp_beat(32'h100, 1'b0, 4'b0000, 32'h0);
    exp_resp(32'h00000080, 1'b0, -1);
    send(1'b0, 3'b100, 32'h103, 32'h0);
    wait_done();
    bus_cfg(0, 0, 32'h80112233, 1'b0, 1'b0, 1'b0, 0);
    exp_beat(32'h100, 1'b0, 4'b0000, 32'h0);
    exp_resp(32'h00008011, 1'b0, 0);
    send(1'b0, 3'b101, 32'h102, 32'h0);
    wait_done();
    bus_cfg(0, 1, 32'h00ABCD00, 1'b0, 1'b0, 1'b0, 0);
    exp_beat(32'h100, 1'b0, 4'b0000, 32'h0);
    exp_resp(32'hFFFFABCD, 1'b0, -1);
    send(1'b0, 3'b001, 32'h101, 32'h0);
    wait_done();

    // SB and SH lane placement
    bus_cfg(0, 1, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    exp_beat(32'h200, 1'b1, 4'b0100, 32'h00AB0000);
    exp_resp(32'h0, 1'b0, -1);
    send(1'b1, 3'b000, 32'h202, 32'h000000AB);
    wait_done();
    bus_cfg(0, 1, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    exp_beat(32'h204, 1'b1, 4'b1100, 32'h12340000);
    exp_resp(32'h0, 1'b0, -1);
    send(1'b1, 3'b001, 32'h206, 32'h00001234);
    wait_done();

    // Misaligned SW at 0x301 and LW at the top of the address space
`ifdef LSU_MISALIGNED_SPLIT_EN
    bus_cfg(0, 1, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    bus_cfg(0, 1, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    exp_beat(32'h300, 1'b1, 4'b1110, 32'hB2C3D400);
    exp_beat(32'h304, 1'b1, 4'b0001, 32'h000000A1);
    exp_resp(32'h0, 1'b0, -1);
    send(1'b1, 3'b010, 32'h301, 32'hA1B2C3D4);
    wait_done();
    bus_cfg(0, 1, 32'h56781111, 1'b0, 1'b0, 1'b0, 0);
    bus_cfg(0, 1, 32'h22221234, 1'b0, 1'b0, 1'b0, 0);
    exp_beat(32'hFFFFFFFC, 1'b0, 4'b0000, 32'h0);
    exp_beat(32'h00000000, 1'b0, 4'b0000, 32'h0);
    exp_resp(32'h12345678, 1'b0, -1);
    send(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    wait_done();
`else
    exp_resp(32'h0, 1'b1, -1);
    send(1'b1, 3'b010, 32'h301, 32'hA1B2C3D4);
    wait_done();
    exp_resp(32'h0, 1'b1, -1);
    send(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    wait_done();
`endif

    // bus_ready held low for 10 cycles
    bus_cfg(10, 1, 32'h12345678, 1'b0, 1'b0, 1'b0, 0);
    exp_beat(32'h10, 1'b0, 4'b0000, 32'h0);
    exp_resp(32'h12345678, 1'b0, 1);
    send(1'b0, 3'b010, 32'h10, 32'h0);
    wait_done();

    // Watchdog: no rvalid, error after 8 wait cycles; late rvalid afterwards is ignored
    bus_cfg(0, 0, 32'h0, 1'b0, 1'b1, 1'b0, 12);
    exp_beat(32'h20, 1'b0, 4'b0000, 32'h0);
    exp_resp(32'h0, 1'b1, 8);
    send(1'b0, 3'b010, 32'h20, 32'h0);
    wait_done();
    repeat (16) @(negedge clk);

    // Bus error
    bus_cfg(0, 1, 32'h55555555, 1'b1, 1'b0, 1'b0, 0);
    exp_beat(32'h40, 1'b0, 4'b0000, 32'h0);
    exp_resp(32'h0, 1'b1, -1);
    send(1'b0, 3'b000, 32'h40, 32'h0);
    wait_done();

    // Illegal funct3: load 011, load 110, store with bit2 set
    exp_resp(32'h0, 1'b1, -1);
    send(1'b0, 3'b011, 32'h100, 32'h0);
    wait_done();
    exp_resp(32'h0, 1'b1, -1);
    send(1'b0, 3'b110, 32'h100, 32'h0);
    wait_done();
    exp_resp(32'h0, 1'b1, -1);
    send(1'b1, 3'b100, 32'h100, 32'h0);
    wait_done();

    // Reset while a beat is still waiting for bus_ready
    bus_cfg(0, 0, 32'h0, 1'b0, 1'b0, 1'b1, 0);
    send(1'b0, 3'b010, 32'h500, 32'h0);
    @(negedge clk);
    check("issue_bus_valid", bus_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_issue_bus_valid", bus_valid, 1'b0);
    check("rst_issue_req_ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in WAIT: transaction is dropped with no response
    bus_cfg(0, 0, 32'h0, 1'b0, 1'b1, 1'b0, 0);
    exp_beat(32'h600, 1'b0, 4'b0000, 32'h0);
    send(1'b0, 3'b010, 32'h600, 32'h0);
    repeat (3) @(negedge clk);
    check("wait_req_ready", req_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_wait_bus_valid", bus_valid, 1'b0);
    check("rst_wait_req_ready", req_ready, 1'b1);
    check("rst_wait_resp_valid", resp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done();
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
